// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged with a 1-cycle latency.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             zpend_q, zpend_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   part_next;
  logic             qbit;
  logic             last;

  // The dividend register doubles as the quotient shift register: each
  // iteration pushes the dividend MSB into the partial remainder and the new
  // quotient bit into the LSB, so after WIDTH steps it holds the quotient.
  assign shifted   = {part_q, dvd_q[WIDTH-1]};
  assign trial     = shifted - {2'b00, dvs_q};
  assign qbit      = ~trial[WIDTH+1];
  assign part_next = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign last      = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (divisor != '0)) state_d = RUN;
      RUN:     if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    zpend_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero divisor accepted last edge completes now; its remainder is
        // the captured dividend, read before any new capture overwrites it.
        if (zpend_q) begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
          quo_d  = '1;
          rem_d  = dvd_q;
        end
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          part_d  = '0;
          cnt_d   = '0;
          zpend_d = (divisor == '0);
          if (!zpend_q) dbz_d = 1'b0;
        end
      end
      RUN: begin
        part_d = part_next;
        dvd_d  = {dvd_q[WIDTH-2:0], qbit};
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          quo_d  = {dvd_q[WIDTH-2:0], qbit};
          rem_d  = part_next[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = done_q;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule
